// File: rtl/cbc_decrypt_ctrl.sv
// rtl/cbc_decrypt_ctrl.sv - CBC/ECB block sequencer and chainer around the Decipher core
//
// Runs one ciphertext block at a time through Decipher.
// For each block it pulses Decipher's reset, waits for decipherDone and
// registers the plaintext result.
//
// With CBC_CHAIN_EN defined:
//   - each Decipher result is XORed with the previous ciphertext block,
//     or with the IV for the first block.
// With CBC_CHAIN_EN undefined (ECB):
//   - the raw Decipher result is emitted;
//   - ivIn and ivLoad are ignored.
//
// Ports:
//   clk, resetN               clock, asynchronous active-low reset
//   keyReady                  key schedule valid; loss while running aborts the block
//   ivIn, ivLoad              IV value and load strobe (honoured in IDLE only)
//   cipherText/Valid/Ready    ciphertext input stream
//   resetDecipher             Decipher reset (1 = held/cleared, 0 = run)
//   decipherIn                ciphertext presented to Decipher
//   decipherOut, decipherDone Decipher result and completion flag
//   plainText/Valid/Ready     plaintext output stream (registered, held until accepted)
//   abortPulse                single-cycle flag on timeout or key loss
`timescale 1ns/1ps

module cbc_decrypt_ctrl #(
    parameter int BLOCK_W        = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               keyReady,
    input  logic [BLOCK_W-1:0] ivIn,
    input  logic               ivLoad,
    input  logic [BLOCK_W-1:0] cipherText,
    input  logic               cipherValid,
    output logic               cipherReady,
    output logic               resetDecipher,
    output logic [BLOCK_W-1:0] decipherIn,
    input  logic [BLOCK_W-1:0] decipherOut,
    input  logic               decipherDone,
    output logic [BLOCK_W-1:0] plainText,
    output logic               plainValid,
    input  logic               plainReady,
    output logic               abortPulse
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   run_cnt;
    logic               accept;
    logic               abort_hit;

`ifdef CBC_CHAIN_EN
    logic [BLOCK_W-1:0] chain;
    logic [BLOCK_W-1:0] ct_buf;

    // A pending IV load takes the IDLE cycle, so no block is taken alongside it.
    assign cipherReady = resetN && (state == IDLE) && keyReady && !ivLoad;
`else
    logic ecb_unused;
    assign ecb_unused  = ^{ivIn, ivLoad};
    assign cipherReady = resetN && (state == IDLE) && keyReady;
`endif

    assign accept        = cipherValid && cipherReady;
    assign resetDecipher = (state != RUN);

    // A completion in the same cycle as a timeout or key loss is still delivered.
    assign abort_hit  = (state == RUN) && !decipherDone &&
                        ((run_cnt == CNT_W'(TIMEOUT_CYCLES)) || !keyReady);
    assign abortPulse = abort_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN: begin
                if (decipherDone)   state_nxt = OUT;
                else if (abort_hit) state_nxt = IDLE;
            end
            OUT: if (plainReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            run_cnt    <= '0;
            decipherIn <= '0;
            plainText  <= '0;
            plainValid <= 1'b0;
`ifdef CBC_CHAIN_EN
            chain      <= '0;
            ct_buf     <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
`ifdef CBC_CHAIN_EN
                    if (ivLoad) chain <= ivIn;
`endif
                    if (accept) begin
                        decipherIn <= cipherText;
`ifdef CBC_CHAIN_EN
                        ct_buf     <= cipherText;
`endif
                    end
                end
                LOAD: run_cnt <= '0;
                RUN: begin
                    if (decipherDone) begin
`ifdef CBC_CHAIN_EN
                        plainText <= decipherOut ^ chain;
                        chain     <= ct_buf;
`else
                        plainText <= decipherOut;
`endif
                        plainValid <= 1'b1;
                    end else if (!abort_hit) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                OUT: if (plainReady) plainValid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cbc_decrypt_ctrl.sv
// tb/tb_cbc_decrypt_ctrl.sv - directed self-checking bench for cbc_decrypt_ctrl
`timescale 1ns/1ps

module tb_cbc_decrypt_ctrl;

    localparam int BW = 128;
    localparam int TO = 64;

    localparam logic [BW-1:0] CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [BW-1:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [BW-1:0] IV_F   = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [BW-1:0] JUNK_O = 128'h0badc0de0badc0de0badc0de0badc0de;

`ifdef CBC_CHAIN_EN
    localparam logic [BW-1:0] EXP_T1 = PT_A;
    localparam logic [BW-1:0] EXP_T2 = 128'h0;
    localparam logic [BW-1:0] EXP_T3 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
    localparam logic [BW-1:0] EXP_T6 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic          CBC    = 1'b1;
`else
    localparam logic [BW-1:0] EXP_T1 = PT_A;
    localparam logic [BW-1:0] EXP_T2 = PT_A;
    localparam logic [BW-1:0] EXP_T3 = PT_A;
    localparam logic [BW-1:0] EXP_T6 = PT_A;
    localparam logic          CBC    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic          keyReady;
    logic [BW-1:0] ivIn;
    logic          ivLoad;
    logic [BW-1:0] cipherText;
    logic          cipherValid;
    logic          cipherReady;
    logic          resetDecipher;
    logic [BW-1:0] decipherIn;
    logic [BW-1:0] decipherOut;
    logic          decipherDone;
    logic [BW-1:0] plainText;
    logic          plainValid;
    logic          plainReady;
    logic          abortPulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Decipher stand-in: answers stub_dly cycles after its reset is released.
    logic stub_en;
    int   stub_dly;
    int   stub_cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetDecipher) stub_cnt <= 0;
        else               stub_cnt <= stub_cnt + 1;
    end

    assign decipherDone = stub_en && !resetDecipher && (stub_cnt >= stub_dly);
    assign decipherOut  = (decipherIn == CT_A) ? PT_A : JUNK_O;

    cbc_decrypt_ctrl #(.BLOCK_W(BW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetN(resetN), .keyReady(keyReady),
        .ivIn(ivIn), .ivLoad(ivLoad),
        .cipherText(cipherText), .cipherValid(cipherValid), .cipherReady(cipherReady),
        .resetDecipher(resetDecipher), .decipherIn(decipherIn),
        .decipherOut(decipherOut), .decipherDone(decipherDone),
        .plainText(plainText), .plainValid(plainValid), .plainReady(plainReady),
        .abortPulse(abortPulse)
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_iv(input logic [BW-1:0] v);
        @(negedge clk);
        ivIn   = v;
        ivLoad = 1'b1;
        @(posedge clk);
        #1 ivLoad = 1'b0;
    endtask

    // Leaves the bench 1 time unit after the accepting edge.
    task automatic send_ct(input logic [BW-1:0] ct);
        int i;
        @(negedge clk);
        cipherText  = ct;
        cipherValid = 1'b1;
        for (i = 0; i < 50 && !cipherReady; i++) @(negedge clk);
        check("accept_ready", cipherReady, 1);
        @(posedge clk);
        #1 cipherValid = 1'b0;
    endtask

    task automatic recv_pt(input string tag, input logic [BW-1:0] exp, input int lat, input int hold);
        int n;
        n = 0;
        while (!plainValid && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        if (lat >= 0) check({tag, "_latency"}, n, lat);
        check({tag, "_valid"}, plainValid, 1);
        check({tag, "_pt"}, plainText, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, plainValid, 1);
            check({tag, "_hold_pt"}, plainText, exp);
            check({tag, "_hold_ready"}, cipherReady, 0);
        end
        plainReady = 1'b1;
        @(posedge clk);
        #1 plainReady = 1'b0;
        check({tag, "_valid_drop"}, plainValid, 0);
        check({tag, "_ready_back"}, cipherReady, 1);
        if (hold > 0) begin
            @(posedge clk);
            #1 check({tag, "_single_hs"}, plainValid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        resetN      = 1'b0;
        keyReady    = 1'b1;
        ivIn        = '0;
        ivLoad      = 1'b0;
        cipherText  = '0;
        cipherValid = 1'b0;
        plainReady  = 1'b0;
        stub_en     = 1'b1;
        stub_dly    = 5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cipherReady", cipherReady, 0);
        check("rst_resetDecipher", resetDecipher, 1);
        check("rst_decipherIn", decipherIn, 0);
        check("rst_plainText", plainText, 0);
        check("rst_plainValid", plainValid, 0);
        check("rst_abortPulse", abortPulse, 0);
        @(negedge clk) resetN = 1'b1;
        #1 check("idle_ready", cipherReady, 1);

        // 1: IV 0, known-answer block; latency is 2 + Decipher delay
        load_iv('0);
        send_ct(CT_A);
        check("t1_decipherIn", decipherIn, CT_A);
        recv_pt("t1", EXP_T1, 2 + 5, 0);

        // 2: IV equal to the plaintext cancels it
        load_iv(PT_A);
        send_ct(CT_A);
        recv_pt("t2", EXP_T2, -1, 0);

        // 3: chained second block
        send_ct(CT_A);
        recv_pt("t3", EXP_T3, -1, 0);

        // 4: done in first RUN cycle, back-pressure for 20 cycles
        stub_dly = 0;
        send_ct(CT_A);
        recv_pt("t4", EXP_T3, 2, 20);
        stub_dly = 5;

        // 5a: Decipher never finishes -> timeout abort
        stub_en = 1'b0;
        send_ct(128'h1234);
        run = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (abortPulse) break;
            if (!resetDecipher) run++;
        end
        check("t5_abort_seen", abortPulse, 1);
        check("t5_abort_at", run, TO);
        check("t5_abort_in_run", resetDecipher, 0);
        @(posedge clk);
        #1;
        check("t5_pulse_one", abortPulse, 0);
        check("t5_idle_ready", cipherReady, 1);
        check("t5_no_output", plainValid, 0);
        check("t5_decipher_held", resetDecipher, 1);

        // 5b: key loss during RUN aborts immediately
        send_ct(128'h5678);
        for (int i = 0; i < 10 && resetDecipher; i++) begin
            @(posedge clk);
            #1;
        end
        keyReady = 1'b0;
        #1 check("t5_keyloss_abort", abortPulse, 1);
        @(posedge clk);
        #1;
        check("t5_keyloss_pulse_one", abortPulse, 0);
        check("t5_nokey_no_accept", cipherReady, 0);
        keyReady = 1'b1;
        #1 check("t5_key_back", cipherReady, 1);

        // 5c: chain still holds CT_A after both aborts
        stub_en = 1'b1;
        send_ct(CT_A);
        recv_pt("t5_chain", EXP_T3, -1, 0);

        // 6: ivLoad and cipherValid together
        @(negedge clk);
        ivIn        = IV_F;
        ivLoad      = 1'b1;
        cipherText  = CT_A;
        cipherValid = 1'b1;
        #1 check("t6_ready_vs_ivload", cipherReady, !CBC);
        @(posedge clk);
        #1;
        ivLoad = 1'b0;
        if (CBC) begin
            send_ct(CT_A);
        end else begin
            cipherValid = 1'b0;
        end
        recv_pt("t6", EXP_T6, -1, 0);

        // 6b: reset mid-RUN
        stub_dly = 30;
        send_ct(CT_A);
        for (int i = 0; i < 10 && resetDecipher; i++) begin
            @(posedge clk);
            #1;
        end
        check("t6_in_run", resetDecipher, 0);
        @(negedge clk) resetN = 1'b0;
        #1;
        check("t6_rst_cipherReady", cipherReady, 0);
        check("t6_rst_resetDecipher", resetDecipher, 1);
        check("t6_rst_decipherIn", decipherIn, 0);
        check("t6_rst_plainText", plainText, 0);
        check("t6_rst_plainValid", plainValid, 0);
        check("t6_rst_abortPulse", abortPulse, 0);
        @(negedge clk) resetN = 1'b1;
        stub_dly = 5;

        // chain cleared by reset: same as test 1 without an IV load
        send_ct(CT_A);
        recv_pt("t6_post_rst", EXP_T1, 7, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
